// File: rtl/irq_arbiter_pkg.sv
// irq_arbiter shared types: FSM states, register offsets, ID width.
// Optional round-robin selection enabled by IRQ_ARBITER_ROUND_ROBIN_EN.
package irq_arbiter_pkg;

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  localparam logic [3:0] ADDR_ENABLE   = 4'h0;
  localparam logic [3:0] ADDR_PENDING  = 4'h4;
  localparam logic [3:0] ADDR_CLAIM    = 4'h8;
  localparam logic [3:0] ADDR_COMPLETE = 4'hC;

  localparam int ID_W = 5;

endpackage

// File: rtl/irq_arbiter_prio_enc.sv
// Rotating-base priority encoder: first set req at or after base, wrapping.
// Returns index+1 as the ID; base=0 gives plain lowest-ID-wins.
module irq_arbiter_prio_enc
  import irq_arbiter_pkg::*;
#(
  parameter int NSRC = 8
) (
  input  logic [NSRC-1:0] req,
  input  logic [ID_W-1:0] base,
  output logic            valid,
  output logic [ID_W-1:0] id
);

  always_comb begin
    int j;
    j     = 0;
    valid = 1'b0;
    id    = '0;
    for (int k = 0; k < NSRC; k++) begin
      j = int'(base) + k;
      if (j >= NSRC) j = j - NSRC;
      if (!valid && req[j]) begin
        valid = 1'b1;
        id    = ID_W'(j + 1);
      end
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// External interrupt controller with claim/complete single-service tracking.
// Define IRQ_ARBITER_ROUND_ROBIN_EN for rotating priority after each claim.
module irq_arbiter
  import irq_arbiter_pkg::*;
#(
  parameter int NSRC = 8
) (
  input  logic            I_clk,
  input  logic            I_rst,
  input  logic [NSRC-1:0] I_src,
  input  logic [3:0]      I_addr,
  input  logic            I_wen,
  input  logic            I_ren,
  input  logic [31:0]     I_wdata,
  output logic [31:0]     O_rdata,
  output logic            O_extinterrupt,
  output logic [ID_W-1:0] O_claimid
);

  state_e state_q, state_d;

  logic [NSRC-1:0] enable_q;
  logic [NSRC-1:0] pending_q;
  logic [NSRC-1:0] pending_d;
  logic [NSRC-1:0] cand;
  logic [NSRC-1:0] svc_mask;
  logic [NSRC-1:0] clr_mask;

  logic [ID_W-1:0] claimid_q;
  logic [ID_W-1:0] claimid_d;
  logic [ID_W-1:0] win_id;
  logic [ID_W-1:0] base;

  logic        win_valid;
  logic        sel_en;
  logic        sel_pend;
  logic        sel_claim;
  logic        sel_cmpl;
  logic        claim_rd;
  logic        cmpl_wr;
  logic        claim_fire;
  logic        irq_q;
  logic [31:0] rdata_d;
  logic [31:0] rdata_q;
  logic        unused_wdata;

  assign sel_en    = I_addr == ADDR_ENABLE;
  assign sel_pend  = I_addr == ADDR_PENDING;
  assign sel_claim = I_addr == ADDR_CLAIM;
  assign sel_cmpl  = I_addr == ADDR_COMPLETE;

  assign cand     = pending_q & enable_q;
  assign claim_rd = I_ren && sel_claim;
  assign cmpl_wr  = I_wen && sel_cmpl;

  assign unused_wdata = ^I_wdata;

  irq_arbiter_prio_enc #(
    .NSRC(NSRC)
  ) u_prio (
    .req  (cand),
    .base (base),
    .valid(win_valid),
    .id   (win_id)
  );

`ifdef IRQ_ARBITER_ROUND_ROBIN_EN
  logic [ID_W-1:0] rr_base_q;

  // Next search starts just past the claimed source.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      rr_base_q <= '0;
    end else if (claim_fire) begin
      rr_base_q <= (win_id == ID_W'(NSRC)) ? '0 : win_id;
    end
  end

  assign base = rr_base_q;
`else
  assign base = '0;
`endif

  always_comb begin
    state_d    = state_q;
    claimid_d  = claimid_q;
    claim_fire = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (claim_rd && win_valid) begin
          claim_fire = 1'b1;
          claimid_d  = win_id;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (cmpl_wr &&
            I_wdata[ID_W-1:0] == claimid_q) begin
          claimid_d = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Claim clears win over a same-edge set of the claimed source.
  always_comb begin
    svc_mask = '0;
    clr_mask = '0;
    for (int i = 0; i < NSRC; i++) begin
      svc_mask[i] = (state_q == BUSY) &&
                    (claimid_q == ID_W'(i + 1));
      clr_mask[i] = claim_fire &&
                    (win_id == ID_W'(i + 1));
    end
    pending_d = (pending_q | (I_src & ~svc_mask))
              & ~clr_mask;
  end

  always_comb begin
    rdata_d = '0;
    unique case (1'b1)
      sel_en:   rdata_d = 32'(enable_q);
      sel_pend: rdata_d = 32'(pending_q);
      sel_claim: begin
        if (state_q == BUSY)
          rdata_d = 32'(claimid_q);
        else if (win_valid)
          rdata_d = 32'(win_id);
      end
      default:  rdata_d = '0;
    endcase
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q   <= IDLE;
      claimid_q <= '0;
      enable_q  <= '0;
      pending_q <= '0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      claimid_q <= claimid_d;
      pending_q <= pending_d;
      if (I_wen && sel_en)
        enable_q <= I_wdata[NSRC-1:0];
      if (I_ren)
        rdata_q <= rdata_d;
      irq_q <= (state_q == IDLE) && !claim_fire
             && (|cand);
    end
  end

  assign O_rdata        = rdata_q;
  assign O_extinterrupt = irq_q;
  assign O_claimid      = claimid_q;

endmodule
